// File: rtl/code_register.sv
// Preset/load register holding a small code word. An asynchronous active-low
// clear has top priority, then synchronous preset, then synchronous parallel load.
module code_register #(
    parameter int unsigned            WIDTH       = 3,
    parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]       SET_VALUE   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] code_reg;

    // Set outranks load; a clear between edges discards any pending request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_reg <= RESET_VALUE;
        end else if (set) begin
            code_reg <= SET_VALUE;
        end else if (load) begin
            code_reg <= data;
        end
    end

    assign out = code_reg;

endmodule

// File: tb/tb_code_register.sv
// Directed bench for code_register: reset, preset, load/hold, priority and
// mid-cycle clear, each checked against hand-computed values.
module tb_code_register;

    logic       clk;
    logic       reset;
    logic       set;
    logic       load;
    logic [2:0] data;
    logic [2:0] out;

    int checks = 0;
    int errors = 0;

    code_register #(
        .WIDTH      (3),
        .RESET_VALUE(3'b000),
        .SET_VALUE  (3'b111)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .set  (set),
        .load (load),
        .data (data),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: out=%b expected=%b at %0t", tag, observed, expected, $time);
        end else begin
            $display("ok   %s: out=%b at %0t", tag, observed, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to a point midway between edges (called right after tick).
    task automatic mid_cycle();
        #3;
    endtask

    initial begin
        reset = 1'b1;
        set   = 1'b0;
        load  = 1'b0;
        data  = 3'b010;

        // Power-up: assert reset before any clock edge
        #1 reset = 1'b0;
        #1 check_val("powerup_async", out, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("powerup_hold", out, 3'b000);
        end

        // Release and hold
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("release_hold", out, 3'b000);
        end

        // Load 010, then clear asynchronously between edges
        load = 1'b1;
        data = 3'b010;
        tick();
        check_val("load_010", out, 3'b010);
        load = 1'b0;
        mid_cycle();
        reset = 1'b0;
        #1 check_val("async_clear", out, 3'b000);
        load = 1'b1;
        data = 3'b101;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("clear_hold", out, 3'b000);
        end
        load  = 1'b0;
        reset = 1'b1;
        tick();
        check_val("release_no_op", out, 3'b000);

        // Preset held for 4 edges, then hold
        set = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("preset", out, 3'b111);
        end
        set = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("preset_hold", out, 3'b111);
        end

        // Load tracking and hold
        load = 1'b1;
        data = 3'b010;
        tick();
        check_val("load_track_010", out, 3'b010);
        data = 3'b101;
        tick();
        check_val("load_track_101", out, 3'b101);
        load = 1'b0;
        data = 3'b011;
        tick();
        check_val("load_off_hold", out, 3'b101);
        data = 3'b000;
        tick();
        check_val("load_off_hold2", out, 3'b101);

        // Priority: set beats load
        set  = 1'b1;
        load = 1'b1;
        data = 3'b010;
        tick();
        check_val("set_over_load", out, 3'b111);

        // Load after set drops, to leave a non-reset value
        set = 1'b0;
        tick();
        check_val("load_after_set", out, 3'b010);

        // Reset beats set and load
        set = 1'b1;
        mid_cycle();
        reset = 1'b0;
        #1 check_val("reset_over_set", out, 3'b000);
        tick();
        check_val("reset_over_set_edge", out, 3'b000);
        reset = 1'b1;
        #1 check_val("release_no_immediate", out, 3'b000);
        tick();
        check_val("set_after_release", out, 3'b111);

        // Pending load discarded by mid-cycle clear, not replayed after release
        set  = 1'b0;
        load = 1'b1;
        data = 3'b110;
        mid_cycle();
        reset = 1'b0;
        #1 check_val("pending_clear", out, 3'b000);
        load = 1'b0;
        #1 reset = 1'b1;
        tick();
        check_val("pending_not_replayed", out, 3'b000);

        // Single-cycle load pulse
        load = 1'b1;
        data = 3'b001;
        tick();
        load = 1'b0;
        data = 3'b100;
        check_val("pulse_load", out, 3'b001);
        tick();
        check_val("pulse_hold", out, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_register.md
Name: code_register

Overview:
- Parameterizable preset/load register holding a small code word.
- Used as a configuration/code-holding element inside datapath blocks.
- Supports three operations: asynchronous clear, synchronous preset to a fixed pattern, and synchronous parallel load from an input bus.
- Holds its value otherwise and drives it continuously on `out`.

Parameters:
- WIDTH, 3, bit width of `data` and `out`; legal range 1..32.
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto `out` while reset is asserted.
- SET_VALUE, {WIDTH{1'b1}}, value loaded on a clock edge when `set` is asserted.

Ports:
- clk  input  1  single clock; all synchronous updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; `reset`=0 forces `out`=RESET_VALUE immediately.
- set  input  1  synchronous preset request, active-high.
- load  input  1  synchronous parallel-load request, active-high.
- data  input  WIDTH  parallel load value.
- out  output  WIDTH  registered contents; driven directly from the storage flops.

Behaviour:
- Storage: one WIDTH-bit register; `out` is the register output with no combinational path from any input.
- Reset assertion:
  - `reset` falling to 0 sets the register to RESET_VALUE asynchronously, with no clock edge required.
  - While `reset`=0, the register stays at RESET_VALUE regardless of clk, set, load or data.
- Reset release:
  - Deassertion (0 to 1) has no immediate effect.
  - The first rising clk edge with `reset`=1 evaluates set/load normally.
  - Inputs must meet recovery/removal timing relative to clk; synchronizing reset is outside this block.
- Priority at each rising clk edge, with `reset`=1:
  1. `set`=1: register <= SET_VALUE; `load` and `data` are ignored.
  2. else if `load`=1: register <= `data`.
  3. else: register holds its value.
- Latency: one clock. A set or load sampled at edge N appears on `out` immediately after edge N. Asynchronous reset has zero cycle latency.
- Level-sensitive controls:
  - Holding `set` high for several cycles re-applies SET_VALUE every edge; the value is stable.
  - Holding `load` high re-samples `data` every edge, so `data` changes are tracked with one cycle latency.
- Simultaneous events:
  - `set` and `load` both high: set wins.
  - `reset`=0 together with set or load: reset wins.
- Reset mid-operation: asserting reset between edges clears `out` at once. The pending set/load is discarded and is not replayed after release.
- No X-propagation requirement: `out` never becomes unknown after the first reset assertion, provided inputs are known at sampled edges.
- Power-up: `out` is undefined until the first reset assertion; the system must assert reset at start-up.
- No internal state other than the WIDTH-bit register. No status outputs. No handshake: requests are single-cycle and always accepted.

Test Plan:
- Power-up: clk period 10, `reset`=0, data=3'b010, set=load=0 → `out`=3'b000 with no clock edge needed; stays 000 across several edges.
- Release and hold: `reset`=1 with set=load=0 for 4 edges → `out` remains 000.
- Asynchronous clear: after loading 3'b010, drop `reset` to 0 midway between edges → `out` becomes 000 before the next edge and stays there until release.
- Preset: `reset`=1, `set`=1 for 4 edges → `out`=3'b111 after the first edge. Then set=0 → `out` holds 111.
- Load and hold:
  - `load`=1, data=3'b010 → `out`=3'b010 after one edge.
  - Change data to 3'b101 while load=1 → `out`=101 after the next edge.
  - load=0 → `out` holds 101 despite further data changes.
- Priority:
  - set=1, load=1, data=3'b010 → `out`=111.
  - `reset`=0 while set=1 and load=1 → `out`=000 immediately.
  - Release reset with set=1 → `out`=111 after the first edge following release.
